// File: rtl/result_drain_if.sv
// Write port from the result drain into the unified/output buffer.
// Handshake: a word transfers on any rising clock edge where wr_valid and
// wr_ready are both 1; once wr_valid is raised the master keeps it and
// wr_addr/wr_data/wr_last unchanged until that transfer happens.
interface result_drain_if #(
    parameter int ADDR_WIDTH       = 8,
    parameter int BUFFER_WORD_SIZE = 16
);
    logic                        wr_valid;
    logic                        wr_ready;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [BUFFER_WORD_SIZE-1:0] wr_data;
    logic                        wr_last;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/result_drain.sv
// Result drain: de-skews the bottom-row results of the systolic array into
// aligned rows, queues them in a small row FIFO and serializes each row into
// buffer-word writes with an auto-incrementing address.
module result_drain #(
    parameter int ARRAY_SIZE             = 8,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int BUFFER_WORD_SIZE       = 16,
    parameter int FIFO_DEPTH             = 4,
    parameter int ADDR_WIDTH             = 8
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]   results_i,
    input  logic                                                results_valid_i,
    input  logic                                                cfg_start_i,
    input  logic [ADDR_WIDTH-1:0]                               cfg_base_addr_i,
    result_drain_if.master                                      wr,
    output logic                                                busy_o,
    output logic                                                overflow_o,
    output logic [15:0]                                         rows_written_o,
    output logic [0:0]                                          state_o
);
    localparam int WORDS_PER_RESULT = ACCUMULATOR_DATA_WIDTH / BUFFER_WORD_SIZE;
    localparam int WORDS_PER_ROW    = ARRAY_SIZE * WORDS_PER_RESULT;
    localparam int ROW_W            = ARRAY_SIZE * ACCUMULATOR_DATA_WIDTH;
    localparam int WIDX_W           = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int PTR_W            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W            = $clog2(FIFO_DEPTH + 1);

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_ROW - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // ------------------------------------------------------------------
    // De-skew: lane j waits ARRAY_SIZE-1-j cycles so that every lane of a
    // row lines up with the last column, which arrives undelayed.
    // ------------------------------------------------------------------
    logic [ACCUMULATOR_DATA_WIDTH-1:0] aligned [ARRAY_SIZE];
    logic [ARRAY_SIZE-2:0]             vld_q;

    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
        localparam int D = ARRAY_SIZE - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j] = results_i[j];
        end else begin : g_dly
            logic [D-1:0][ACCUMULATOR_DATA_WIDTH-1:0] dly_q;
            // Per-lane delay line, shifts every cycle
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dly_q <= '0;
                end else begin
                    dly_q[0] <= results_i[j];
                    for (int k = 1; k < D; k++) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end
            assign aligned[j] = dly_q[D-1];
        end
    end

    // Row-valid delay line matching the longest lane delay
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= results_valid_i;
            for (int k = 1; k < ARRAY_SIZE - 1; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Flatten the aligned lanes: lane 0 occupies the least-significant bits,
    // so word k of the row is simply row[k*BUFFER_WORD_SIZE +: BUFFER_WORD_SIZE].
    logic [ROW_W-1:0] row_in;
    always_comb begin
        row_in = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            row_in[j*ACCUMULATOR_DATA_WIDTH +: ACCUMULATOR_DATA_WIDTH] = aligned[j];
        end
    end

    // ------------------------------------------------------------------
    // Row FIFO and serializer state
    // ------------------------------------------------------------------
    logic [ROW_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [0:0]            state_q, state_d;
    logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           rows_q, rows_d;
    logic                  ovf_q, ovf_d;

    logic [ROW_W-1:0] head;
    logic             push_req, push_ok, drop, pop;
    logic             sending, accept, is_last, fifo_full;

    assign head      = mem_q[rd_ptr_q];
    assign push_req  = vld_q[ARRAY_SIZE-2];
    assign sending   = (state_q == ST_SEND);
    assign accept    = sending && wr.wr_ready;
    assign is_last   = (word_idx_q == LAST_WORD);
    assign pop       = accept && is_last;
    assign fifo_full = (count_q == FULL_CNT);
    // A pop in the same cycle frees the slot before the push is judged.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;

    // Next-state logic for FIFO pointers, serializer FSM and counters
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        rows_d     = rows_q;
        ovf_d      = ovf_q;

        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                // Start straight off the incoming push so the first word is
                // presented the cycle after the row lands in the FIFO.
                if ((count_q != '0) || push_ok) begin
                    state_d    = ST_SEND;
                    word_idx_d = '0;
                end
            end
            default: begin
                if (accept) begin
                    if (is_last) begin
                        word_idx_d = '0;
                        state_d    = ((count_q > CNT_W'(1)) || push_ok) ? ST_SEND : ST_IDLE;
                    end else begin
                        word_idx_d = word_idx_q + WIDX_W'(1);
                    end
                end
            end
        endcase

        // cfg_start outranks any same-cycle address step, row count or drop.
        if (cfg_start_i) begin
            addr_d = cfg_base_addr_i;
            rows_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (accept) addr_d = addr_q + ADDR_WIDTH'(1);
            if (pop)    rows_d = rows_q + 16'd1;
            if (drop)   ovf_d  = 1'b1;
        end
    end

    // Control and status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            rows_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            rows_q     <= rows_d;
            ovf_q      <= ovf_d;
        end
    end

    // Row storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= row_in;
        end
    end

    // Outputs are decoded from registered state only, so they stay stable
    // for as long as a word is stalled.
    assign wr.wr_valid    = sending;
    assign wr.wr_data     = sending ? head[word_idx_q*BUFFER_WORD_SIZE +: BUFFER_WORD_SIZE] : '0;
    assign wr.wr_last     = sending && is_last;
    assign wr.wr_addr     = addr_q;
    assign busy_o         = (|vld_q) || (count_q != '0) || sending;
    assign overflow_o     = ovf_q;
    assign rows_written_o = rows_q;
    assign state_o        = state_q;
endmodule
